// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        StHunt    = 2'd0,
        StRestart = 2'd1,
        StCfg     = 2'd2
    } state_t;

    localparam logic [7:0]  DefaultPat = 8'b0000_1011;
    localparam int unsigned DefaultLen = 4;

    function automatic logic len_legal(input int unsigned len, input int unsigned max);
        return (len != 0) && (len <= max);
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Valid-gated history shift register with a saturating fill counter.
module seq_det_hist #(
    parameter int unsigned MaxLen = 8,
    localparam int unsigned FillW = $clog2(MaxLen + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic              bit_i,
    input  logic              clr_i,
    output logic [MaxLen-1:0] hist_nxt_o,
    output logic [FillW-1:0]  fill_nxt_o
);

    logic [MaxLen-1:0] hist_q;
    logic [FillW-1:0]  fill_q;

    // Next values assume the bit is taken; the caller gates them with valid.
    always_comb begin
        hist_nxt_o = (hist_q << 1) | MaxLen'(bit_i);
        fill_nxt_o = (fill_q == FillW'(MaxLen)) ? fill_q : fill_q + FillW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (valid_i) begin
            hist_q <= hist_nxt_o;
            fill_q <= fill_nxt_o;
        end
    end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial bit-sequence detector with saturating match counter.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN = 8,
    parameter int unsigned        CNT_W   = 16,
    parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(DefaultPat),
    parameter int unsigned        RST_LEN = DefaultLen,
    localparam int unsigned       LenW    = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    input  logic               in_i,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pat_i,
    input  logic [LenW-1:0]    cfg_len_i,
    input  logic               cfg_overlap_i,
    input  logic               cnt_clr_i,
    output logic               out_o,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic               cfg_err_o
);

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LenW-1:0]    len_q;
    logic               ovl_q;
    logic               out_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [LenW-1:0]    fill_nxt;
    logic [MAX_LEN-1:0] mask;
    logic               load_ok;
    logic               hit;
    logic               fire;
    logic               hist_clr;

    seq_det_hist #(
        .MaxLen (MAX_LEN)
    ) u_hist (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (in_valid_i),
        .bit_i      (in_i),
        .clr_i      (hist_clr),
        .hist_nxt_o (hist_nxt),
        .fill_nxt_o (fill_nxt)
    );

    always_comb begin
        load_ok = cfg_load_i && len_legal(32'(cfg_len_i), MAX_LEN);
        mask    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LenW'(i) < len_q);
        end
        hit = in_valid_i && (fill_nxt >= len_q) && (((hist_nxt ^ pat_q) & mask) == '0);

        fire     = 1'b0;
        hist_clr = 1'b0;
        case (state_q)
            StHunt, StRestart: fire = hit && !load_ok;
            StCfg:             hist_clr = 1'b1;
            default:           hist_clr = 1'b1;
        endcase
        // Non-overlapping matches drop the history so matched bits are not reused.
        if (load_ok || (fire && !ovl_q)) begin
            hist_clr = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StHunt;
            pat_q   <= RST_PAT;
            len_q   <= LenW'(RST_LEN);
            ovl_q   <= 1'b1;
            out_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            out_q <= fire;

            if (cnt_clr_i) begin
                cnt_q <= CNT_W'(fire);
            end else if (fire && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (cfg_load_i) begin
                err_q <= !load_ok;
            end
            if (load_ok) begin
                pat_q <= cfg_pat_i;
                len_q <= cfg_len_i;
                ovl_q <= cfg_overlap_i;
            end

            if (load_ok) begin
                state_q <= StCfg;
            end else if (fire && !ovl_q) begin
                state_q <= StRestart;
            end else begin
                state_q <= StHunt;
            end
        end
    end

    assign out_o       = out_q;
    assign match_cnt_o = cnt_q;
    assign cfg_err_o   = err_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed plus random stimulus against a bit-queue reference model; two builds (CNT_W 16 and 2).
module tb_seq_det_prog;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_bit;
    logic        cfg_load;
    logic [7:0]  cfg_pat;
    logic [3:0]  cfg_len;
    logic        cfg_ovl;
    logic        cnt_clr;
    logic        out;
    logic [15:0] cnt;
    logic        err;
    logic        out2;
    logic [1:0]  cnt2;
    logic        err2;

    int n_pass = 0;
    int n_fail = 0;

    // Reference model state
    bit          m_q[$];
    logic [7:0]  m_pat;
    int          m_len;
    logic        m_ovl;
    logic        m_err;
    logic        m_drop;
    logic        m_out;
    int          m_cnt;
    int          m_cnt2;

    seq_det_prog u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_i          (in_bit),
        .cfg_load_i    (cfg_load),
        .cfg_pat_i     (cfg_pat),
        .cfg_len_i     (cfg_len),
        .cfg_overlap_i (cfg_ovl),
        .cnt_clr_i     (cnt_clr),
        .out_o         (out),
        .match_cnt_o   (cnt),
        .cfg_err_o     (err)
    );

    seq_det_prog #(
        .CNT_W (2)
    ) u_sat (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_i          (in_bit),
        .cfg_load_i    (cfg_load),
        .cfg_pat_i     (cfg_pat),
        .cfg_len_i     (cfg_len),
        .cfg_overlap_i (cfg_ovl),
        .cnt_clr_i     (cnt_clr),
        .out_o         (out2),
        .match_cnt_o   (cnt2),
        .cfg_err_o     (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        assert (got === want) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pat  = 8'b0000_1011;
        m_len  = 4;
        m_ovl  = 1'b1;
        m_err  = 1'b0;
        m_drop = 1'b0;
        m_out  = 1'b0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    // Pattern bit [len-1] is the oldest of the last len received bits.
    task automatic model_step();
        logic legal;
        logic hit;
        legal = cfg_load && (cfg_len >= 1) && (cfg_len <= 8);
        hit   = 1'b0;
        if (legal) begin
            m_q.delete();
            m_pat  = cfg_pat;
            m_len  = int'(cfg_len);
            m_ovl  = cfg_ovl;
            m_err  = 1'b0;
            m_drop = 1'b1;
        end else begin
            if (cfg_load) m_err = 1'b1;
            if (m_drop) begin
                m_drop = 1'b0;
            end else if (in_valid) begin
                m_q.push_back(in_bit);
                if (m_q.size() > 8) void'(m_q.pop_front());
                if (m_q.size() >= m_len) begin
                    hit = 1'b1;
                    for (int i = 0; i < m_len; i++) begin
                        if (m_q[m_q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
                    end
                end
                if (hit && !m_ovl) m_q.delete();
            end
        end
        if (cnt_clr) begin
            m_cnt  = int'(hit);
            m_cnt2 = int'(hit);
        end else if (hit) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        m_out = hit;
    endtask

    task automatic check_all();
        check("out", 32'(out), 32'(m_out));
        check("match_cnt", 32'(cnt), m_cnt);
        check("cfg_err", 32'(err), 32'(m_err));
        check("out_sat", 32'(out2), 32'(m_out));
        check("match_cnt_sat", 32'(cnt2), m_cnt2);
        check("cfg_err_sat", 32'(err2), 32'(m_err));
    endtask

    task automatic cyc(input logic v, input logic b, input logic ld, input logic [7:0] p,
                       input logic [3:0] l, input logic o, input logic c);
        in_valid = v;
        in_bit   = b;
        cfg_load = ld;
        cfg_pat  = p;
        cfg_len  = l;
        cfg_ovl  = o;
        cnt_clr  = c;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, seq[i], 1'b0, 8'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cyc(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
        idle();
    endtask

    initial begin
        logic [7:0] rp;
        logic [3:0] rl;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        cfg_load = 1'b0;
        cfg_pat  = '0;
        cfg_len  = '0;
        cfg_ovl  = 1'b0;
        cnt_clr  = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset pattern 1011, overlapping
        send(8'b0101_1011, 7);
        check("default_cnt", 32'(cnt), 32'd2);

        // Illegal length keeps old pattern, then a legal 2-bit load
        cyc(1'b0, 1'b0, 1'b1, 8'h55, 4'd0, 1'b0, 1'b0);
        check("illegal_err", 32'(err), 32'd1);
        send(8'b0000_1011, 4);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 4'd9, 1'b0, 1'b0);
        load(8'b01, 4'd2, 1'b1);
        check("legal_err", 32'(err), 32'd0);
        send(8'b01, 2);

        // 111 overlapping, then non-overlapping
        load(8'b111, 4'd3, 1'b1);
        send(8'b1_1111, 5);
        load(8'b111, 4'd3, 1'b0);
        send(8'b11_1111, 6);

        // Full-length pattern with a valid gap mid-stream
        load(8'b1010_0110, 4'd8, 1'b1);
        send(8'b101, 3);
        idle();
        idle();
        send(8'b0_0110, 5);

        // Match coinciding with cnt_clr, and with cfg_load
        load(8'b01, 4'd2, 1'b1);
        send(8'b010101, 6);
        cyc(1'b1, 1'b0, 1'b0, 8'h0, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h0, 4'h0, 1'b0, 1'b1);
        check("clr_with_match", 32'(cnt), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 8'h0, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'b11, 4'd2, 1'b1, 1'b0);
        check("load_beats_match", 32'(out), 32'd0);
        idle();

        // Asynchronous reset mid-pattern
        load(8'b1011, 4'd4, 1'b1);
        send(8'b101, 3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'b1, 1);

        // Random traffic including loads, gaps and clears
        for (int k = 0; k < 600; k++) begin
            rp = 8'($urandom);
            rl = 4'($urandom_range(0, 10));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 24) == 0),
                rp, rl, 1'($urandom), 1'($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Programmable serial bit-sequence detector. Successor to the fixed 4-bit detector.
- Pattern and length are loaded at runtime, up to MAX_LEN bits.
- Overlapping or non-overlapping detection is selectable; input is gated by a valid qualifier.
- Keeps a saturating match counter. Sits on the serial input path feeding status/interrupt logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 16, width of the match counter.
- RST_PAT, 8'b0000_1011, pattern active after reset (LSB-aligned).
- RST_LEN, 4, pattern length active after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  qualifies `in`; bit is consumed only when high.
- in  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe: latch cfg_pat, cfg_len, cfg_overlap.
- cfg_pat  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- out  out  1  registered one-cycle match pulse.
- match_cnt  out  CNT_W  saturating count of matches.
- cfg_err  out  1  sticky flag: last cfg_load carried an illegal length.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out=0, match_cnt=0, cfg_err=0.
  - pat=RST_PAT, len=RST_LEN, overlap=1.
  - History shift register hist=0, fill counter fill=0.
  - FSM state = HUNT.
- Datapath:
  - On each in_valid cycle, hist <= {hist[MAX_LEN-2:0], in}.
  - fill increments, saturating at MAX_LEN.
- Match condition, evaluated on the updated history, combinationally from the current hist/fill/in:
  - fill_next >= len, and
  - hist_next[len-1:0] == pat[len-1:0].
- Latency: out is high in the cycle after the clock edge that sampled the final pattern bit. This is one registered stage, the same as the previous generation.
- out is low whenever in_valid was low on the prior edge. A single cycle never produces two pulses.
- FSM states:
  - HUNT: normal sampling. On match, out_next=1, match_cnt+1.
    - overlap=1: history kept, stay HUNT.
    - overlap=0: go to RESTART.
  - RESTART: entered for exactly one clock after a non-overlapping match.
    - fill is cleared to 0 on the transition into this state, so bits of the matched sequence cannot be reused.
    - If in_valid is high in RESTART, the bit is sampled normally (fill becomes 1) and the state returns to HUNT.
    - With in_valid low it also returns to HUNT.
  - CFG: entered for one clock on a legal cfg_load.
    - Pattern registers are updated and hist/fill are cleared.
    - Any in_valid bit in this cycle is discarded.
    - Returns to HUNT next cycle.
- Configuration legality: a cfg_load with cfg_len==0 or cfg_len>MAX_LEN is ignored and sets cfg_err. A legal load clears cfg_err.
- Simultaneous events:
  - cfg_load with a match in the same cycle: cfg_load wins. No pulse and no count for that cycle.
  - cnt_clr with a match: counter ends at 1.
- match_cnt saturates at all-ones and does not wrap.
- Reset mid-pattern: all history is lost and detection restarts from the reset pattern.
- Any undefined FSM encoding returns to HUNT with fill=0 (default branch).

Decomposition:
- Package seq_det_pkg holds:
  - enum state_t {HUNT, RESTART, CFG};
  - localparam default pattern/length;
  - function len_legal(len, max).
- One natural sub-module, seq_det_hist: the valid-gated shift register plus saturating fill counter, with a clear input. Comparison logic and the FSM stay in the top.

Test Plan:
- Reset defaults, overlap: in_valid=1, stream 1,0,1,1,0,1,1 -> out pulses on the cycles after bits 4 and 7; match_cnt=2.
- Overlap with pattern 111, len=3: stream five 1s -> pulses after bits 3, 4, 5; match_cnt=3. Repeat with overlap=0 -> single pulse after bit 3 only; a sixth 1 gives a second pulse after bit 6.
- Full length, pattern 8'b1010_0110, len=8: send the pattern with in_valid low for 2 cycles between bits 3 and 4 -> exactly one pulse, and only after bit 8.
- Illegal config: cfg_load with cfg_len=0 -> cfg_err=1 and the old pattern still detects 1011. Then a legal load with len=2, pat=01 -> cfg_err=0; stream 0,1 -> pulse.
- Saturation and clear, CNT_W=2 build: 5 matches -> match_cnt=3. cnt_clr in the same cycle as a match -> match_cnt=1.
- Async reset asserted mid-stream after 1,0,1 -> out=0 and match_cnt=0 immediately. After release, a single following 1 produces no pulse.
